vx_commit_writeback_arb: RTL and testbench
==========================================

// Module: vx_commit_writeback_arb
// PURPOSE
//  Writeback stage directly downstream of the per-unit commit interfaces (ALU, LSU, CSR, FPU, GPU).
//  Arbitrates NUM_REQS commit streams round-robin and registers the winner into one writeback
//  stream feeding the GPR file.
//  Commits with wb=0 retire without a register write. Maintains a 64-bit retired-instruction
//  counter (eop events) for the CSR unit.
// PARAMETERS
//  NUM_REQS     5   number of commit sources
//  NUM_THREADS  4   lanes per warp
//  NW_BITS      2   warp id width
//  NR_BITS      6   register index width
//  UUID_BITS    44  instruction uuid width
// PORTS
//  clk             in   1                   clock
//  reset_n         in   1                   async active-low reset
//  commit_valid    in   NUM_REQS            per-source commit valid
//  commit_uuid     in   NUM_REQS*UUID_BITS  per-source uuid
//  commit_wid      in   NUM_REQS*NW_BITS    per-source warp id
//  commit_tmask    in   NUM_REQS*NUM_THREADS  per-source thread mask
//  commit_PC       in   NUM_REQS*32         per-source PC
//  commit_data     in   NUM_REQS*NUM_THREADS*32  per-source lane results
//  commit_rd       in   NUM_REQS*NR_BITS    per-source destination register
//  commit_wb       in   NUM_REQS            1 = write rd
//  commit_eop      in   NUM_REQS            end of packet (last beat of instruction)
//  commit_ready    out  NUM_REQS            per-source accept
//  wb_valid        out  1                   writeback valid
//  wb_uuid/wid/tmask/PC/rd/data/eop  out  as above  registered winner fields
//  wb_ready        in   1                   GPR file accepts
//  instret         out  64                  retired instruction count
// BEHAVIOUR
//  Reset: one clock; reset asynchronous, active-low (reset_n). On assertion: wb_valid=0,
//   all wb_* payload=0, rr pointer=0, instret=0. Reset mid-transfer drops the held entry;
//   no partial writeback.
//  Handshake: valid/ready per source. A source holds valid and payload until commit_ready.
//   Transfer occurs on valid&&ready.
//  Non-wb path: commit_ready[i]=1 whenever commit_valid[i]&&!commit_wb[i], same cycle,
//   independent of output stall. Never reaches wb_*.
//  wb path: requesters req[i]=commit_valid[i]&&commit_wb[i].
//   Round-robin grant from pointer p: first req at index p, p+1, .. wrapping mod NUM_REQS.
//   stage_en = !wb_valid || wb_ready.
//   commit_ready[i] = grant[i] && stage_en for wb requests.
//  Output register: on stage_en, wb_valid<=|req and the winner payload loads.
//   If no req, wb_valid<=0 and payload holds. Latency exactly 1 cycle commit->wb_valid.
//   Full throughput with wb_ready=1. While wb_valid&&!wb_ready, outputs are frozen.
//  Pointer: on accepted grant g, p<=(g+1)==NUM_REQS ? 0 : g+1. Holds on stall or no request.
//   A new higher-priority requester may displace the grant while stalled.
//  instret: += popcount of accepted commits with eop=1 this cycle, wb and non-wb combined
//   (max NUM_REQS per cycle). Sum is zero-extended; wraps mod 2^64. Counts at acceptance,
//   not at wb output.
//  Single-source: NUM_REQS=1 degenerates to a pipe register; pointer is constant 0.
//  No X on ready: commit_ready[i]=0 when commit_valid[i]=0.
// STRUCTURE
//  Package vx_wb_pkg: commit_req_t struct {uuid,wid,tmask,PC,data,rd,eop}; width localparams;
//   RR pointer width = $clog2(NUM_REQS) (min 1).
//  Sub-module vx_rr_arbiter (NUM_REQS): req, pointer-advance enable -> one-hot grant + index;
//   owns the pointer register.
//  Top: payload mux, output register, non-wb ack logic, instret adder.
// TESTING
//  1. Reset release, no traffic -> wb_valid=0, instret=0, all commit_ready=0.
//  2. Src0 wb=1 rd=5 data=0x11 eop=1, wb_ready=1 -> next cycle wb_valid=1 rd=5 data=0x11;
//     instret=1.
//  3. All 5 sources wb=1 continuously, wb_ready=1 -> grants 0,1,2,3,4,0 on successive cycles;
//     one transfer/cycle.
//  4. wb_ready=0 for 3 cycles with wb_valid=1 -> wb_* stable, wb-source ready=0;
//     non-wb src2 eop=1 acked each cycle, instret +1/cycle.
//  5. Same cycle: src1 wb=1 eop=1, src3 wb=0 eop=1, src4 wb=0 eop=0 -> all three accepted;
//     instret +2.
//  6. instret preset near 2^64-1 via 2 eop retires -> wraps to 0/1. reset_n low while
//     wb_valid=1 -> wb_valid=0 immediately (async).

Source files
------------

// File: rtl/vx_commit_writeback_arb_pkg.sv
// Shared widths and the commit payload record for the commit writeback arbiter.
// The struct field order matches the packing used by the top-level payload mux.
package vx_wb_pkg;

    localparam int NUM_REQS    = 5;
    localparam int NUM_THREADS = 4;
    localparam int NW_BITS     = 2;
    localparam int NR_BITS     = 6;
    localparam int UUID_BITS   = 44;
    localparam int DATA_BITS   = NUM_THREADS * 32;
    localparam int PTR_BITS    = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;

    typedef struct packed {
        logic [UUID_BITS-1:0]   uuid;
        logic [NW_BITS-1:0]     wid;
        logic [NUM_THREADS-1:0] tmask;
        logic [31:0]            PC;
        logic [DATA_BITS-1:0]   data;
        logic [NR_BITS-1:0]     rd;
        logic                   eop;
    } commit_req_t;

endpackage

// File: rtl/vx_commit_writeback_arb_if.sv
// Commit-side and writeback-side bundle of the writeback arbiter.
// slave = the arbiter, master = whoever drives commits and sinks writebacks.
interface vx_commit_writeback_arb_if;
    import vx_wb_pkg::*;

    logic [NUM_REQS-1:0]             commit_valid;
    logic [NUM_REQS*UUID_BITS-1:0]   commit_uuid;
    logic [NUM_REQS*NW_BITS-1:0]     commit_wid;
    logic [NUM_REQS*NUM_THREADS-1:0] commit_tmask;
    logic [NUM_REQS*32-1:0]          commit_PC;
    logic [NUM_REQS*DATA_BITS-1:0]   commit_data;
    logic [NUM_REQS*NR_BITS-1:0]     commit_rd;
    logic [NUM_REQS-1:0]             commit_wb;
    logic [NUM_REQS-1:0]             commit_eop;
    logic [NUM_REQS-1:0]             commit_ready;

    logic                            wb_valid;
    logic [UUID_BITS-1:0]            wb_uuid;
    logic [NW_BITS-1:0]              wb_wid;
    logic [NUM_THREADS-1:0]          wb_tmask;
    logic [31:0]                     wb_PC;
    logic [NR_BITS-1:0]              wb_rd;
    logic [DATA_BITS-1:0]            wb_data;
    logic                            wb_eop;
    logic                            wb_ready;

    logic [63:0]                     instret;

    modport slave (
        input  commit_valid, commit_uuid, commit_wid, commit_tmask, commit_PC,
               commit_data, commit_rd, commit_wb, commit_eop,
        output commit_ready,
        output wb_valid, wb_uuid, wb_wid, wb_tmask, wb_PC, wb_rd, wb_data, wb_eop,
        input  wb_ready,
        output instret
    );

    modport master (
        output commit_valid, commit_uuid, commit_wid, commit_tmask, commit_PC,
               commit_data, commit_rd, commit_wb, commit_eop,
        input  commit_ready,
        input  wb_valid, wb_uuid, wb_wid, wb_tmask, wb_PC, wb_rd, wb_data, wb_eop,
        output wb_ready,
        input  instret
    );

endinterface

// File: rtl/vx_commit_writeback_arb_rr.sv
// Round-robin arbiter: scans from the pointer upward with wrap, returns one-hot grant
// plus index, and moves the pointer past the winner only when the grant is accepted.
module vx_rr_arbiter #(
    parameter  int NUM_REQS = 5,
    localparam int PTR_BITS = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [NUM_REQS-1:0] req,
    input  logic                advance,
    output logic [NUM_REQS-1:0] grant,
    output logic [PTR_BITS-1:0] grant_idx
);

    logic [PTR_BITS-1:0] ptr_q;
    logic                found;
    int                  scan;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        scan      = 0;
        for (int i = 0; i < NUM_REQS; i++) begin
            scan = int'(ptr_q) + i;
            if (scan >= NUM_REQS) begin
                scan = scan - NUM_REQS;
            end
            if (!found && req[scan]) begin
                found       = 1'b1;
                grant[scan] = 1'b1;
                grant_idx   = PTR_BITS'(scan);
            end
        end
    end

    // With a single source the wrap test is always true, so the pointer stays at 0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q <= '0;
        end else if (advance) begin
            ptr_q <= (int'(grant_idx) == NUM_REQS - 1) ? '0 : grant_idx + PTR_BITS'(1);
        end
    end

endmodule

// File: rtl/vx_commit_writeback_arb.sv
// Writeback stage: round-robin merge of the commit streams into one registered GPR
// writeback, same-cycle ack for non-writing commits, and the retired-instruction counter.
module vx_commit_writeback_arb
    import vx_wb_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset_n,
    vx_commit_writeback_arb_if.slave bus
);

    commit_req_t         reqs [NUM_REQS];
    commit_req_t         sel_req;
    commit_req_t         wb_q;
    logic [NUM_REQS-1:0] req;
    logic [NUM_REQS-1:0] grant;
    logic [NUM_REQS-1:0] nowb_ack;
    logic [NUM_REQS-1:0] commit_ready;
    logic [NUM_REQS-1:0] retired;
    logic [PTR_BITS-1:0] grant_idx;
    logic                wb_valid_q;
    logic                stage_en;
    logic                any_req;
    logic [63:0]         instret_q;

    for (genvar i = 0; i < NUM_REQS; i++) begin : g_unpack
        assign reqs[i] = {bus.commit_uuid [i*UUID_BITS   +: UUID_BITS],
                          bus.commit_wid  [i*NW_BITS     +: NW_BITS],
                          bus.commit_tmask[i*NUM_THREADS +: NUM_THREADS],
                          bus.commit_PC   [i*32          +: 32],
                          bus.commit_data [i*DATA_BITS   +: DATA_BITS],
                          bus.commit_rd   [i*NR_BITS     +: NR_BITS],
                          bus.commit_eop  [i]};
    end

    assign req      = bus.commit_valid & bus.commit_wb;
    assign any_req  = |req;
    assign stage_en = !wb_valid_q || bus.wb_ready;

    vx_rr_arbiter #(
        .NUM_REQS (NUM_REQS)
    ) u_arb (
        .clk       (clk),
        .reset_n   (reset_n),
        .req       (req),
        .advance   (stage_en && any_req),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign sel_req = reqs[grant_idx];

    // Non-writing commits never touch the output register, so they ignore backpressure.
    assign nowb_ack     = bus.commit_valid & ~bus.commit_wb;
    assign commit_ready = nowb_ack | (grant & {NUM_REQS{stage_en}});
    assign retired      = bus.commit_valid & commit_ready & bus.commit_eop;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wb_valid_q <= 1'b0;
            wb_q       <= '0;
        end else if (stage_en) begin
            wb_valid_q <= any_req;
            if (any_req) begin
                wb_q <= sel_req;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            instret_q <= '0;
        end else begin
            instret_q <= instret_q + 64'($countones(retired));
        end
    end

    assign bus.commit_ready = commit_ready;
    assign bus.wb_valid     = wb_valid_q;
    assign bus.wb_uuid      = wb_q.uuid;
    assign bus.wb_wid       = wb_q.wid;
    assign bus.wb_tmask     = wb_q.tmask;
    assign bus.wb_PC        = wb_q.PC;
    assign bus.wb_rd        = wb_q.rd;
    assign bus.wb_data      = wb_q.data;
    assign bus.wb_eop       = wb_q.eop;
    assign bus.instret      = instret_q;

endmodule

// File: tb/tb_vx_commit_writeback_arb.sv
// Scoreboard bench for the commit writeback arbiter: directed scenarios followed by
// a randomized traffic phase, all checked against a cycle model kept in the bench.
module tb_vx_commit_writeback_arb;
    import vx_wb_pkg::*;

    logic clk;
    logic reset_n;

    vx_commit_writeback_arb_if bus ();

    vx_commit_writeback_arb dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    commit_req_t         src_pl [NUM_REQS];
    logic [NUM_REQS-1:0] cv;
    logic [NUM_REQS-1:0] cwb;
    logic [NUM_REQS-1:0] last_acc;
    int                  seq [NUM_REQS];

    logic                m_wbv;
    int                  m_ptr;
    logic [63:0]         m_instret;
    commit_req_t         sb [$];

    task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic commit_req_t make_req(int src, int sq, logic eop);
        commit_req_t r;
        r.uuid  = UUID_BITS'(src * 4096 + sq);
        r.wid   = NW_BITS'(sq);
        r.tmask = NUM_THREADS'(sq + src + 1);
        r.PC    = 32'h8000_0000 + 32'(src * 256 + sq * 4);
        r.data  = {32'(sq * 7), 32'(src), 32'hA5A5_0000 ^ 32'(sq), 32'(sq + src)};
        r.rd    = {3'(src), 3'(sq)};
        r.eop   = eop;
        return r;
    endfunction

    task automatic apply();
        bus.commit_valid = cv;
        bus.commit_wb    = cwb;
        for (int i = 0; i < NUM_REQS; i++) begin
            bus.commit_uuid [i*UUID_BITS   +: UUID_BITS]   = src_pl[i].uuid;
            bus.commit_wid  [i*NW_BITS     +: NW_BITS]     = src_pl[i].wid;
            bus.commit_tmask[i*NUM_THREADS +: NUM_THREADS] = src_pl[i].tmask;
            bus.commit_PC   [i*32          +: 32]          = src_pl[i].PC;
            bus.commit_data [i*DATA_BITS   +: DATA_BITS]   = src_pl[i].data;
            bus.commit_rd   [i*NR_BITS     +: NR_BITS]     = src_pl[i].rd;
            bus.commit_eop  [i]                            = src_pl[i].eop;
        end
    endtask

    // One clock: entered just after a falling edge, left just after the next one.
    task automatic tick(input logic dir_en = 1'b0, input logic [NUM_REQS-1:0] dir_ready = '0);
        logic [NUM_REQS-1:0] req;
        logic [NUM_REQS-1:0] grant;
        logic [NUM_REQS-1:0] exp_ready;
        logic [NUM_REQS-1:0] eops;
        logic                stage_en;
        int                  g;
        apply();
        #1;
        req      = cv & cwb;
        stage_en = !m_wbv || bus.wb_ready;
        grant    = '0;
        g        = -1;
        for (int k = 0; k < NUM_REQS; k++) begin
            int j;
            j = (m_ptr + k) % NUM_REQS;
            if (g < 0 && req[j]) g = j;
        end
        if (g >= 0) grant[g] = 1'b1;
        exp_ready = (cv & ~cwb) | (stage_en ? grant : '0);
        check_val("commit_ready", 256'(bus.commit_ready), 256'(exp_ready));
        if (dir_en) check_val("directed_ready", 256'(bus.commit_ready), 256'(dir_ready));
        check_val("wb_valid", 256'(bus.wb_valid), 256'(m_wbv));
        if (m_wbv) begin
            if (sb.size() == 0) begin
                check_val("sb_depth", 256'(sb.size()), 256'(1));
            end else begin
                check_val("wb_payload",
                          256'({bus.wb_uuid, bus.wb_wid, bus.wb_tmask, bus.wb_PC,
                                bus.wb_data, bus.wb_rd, bus.wb_eop}),
                          256'(sb[0]));
                if (bus.wb_ready) void'(sb.pop_front());
            end
        end
        for (int i = 0; i < NUM_REQS; i++) eops[i] = src_pl[i].eop;
        last_acc  = exp_ready & cv;
        m_instret = m_instret + 64'($countones(last_acc & eops));
        if (stage_en) begin
            m_wbv = |req;
            if (g >= 0) begin
                sb.push_back(src_pl[g]);
                m_ptr = (g + 1) % NUM_REQS;
            end
        end
        @(posedge clk);
        @(negedge clk);
        check_val("instret", 256'(bus.instret), 256'(m_instret));
        cv = cv & ~last_acc;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        cv      = '0;
        cwb     = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            src_pl[i] = '0;
            seq[i]    = 0;
        end
        bus.wb_ready = 1'b0;
        apply();
        m_wbv     = 1'b0;
        m_ptr     = 0;
        m_instret = '0;
        sb.delete();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        logic [63:0] base;
        int          rr_order [6] = '{0, 1, 2, 3, 4, 0};

        // reset, idle
        do_reset();
        check_val("rst_instret", 256'(bus.instret), 256'(0));
        check_val("rst_ready", 256'(bus.commit_ready), 256'(0));
        check_val("rst_wb_valid", 256'(bus.wb_valid), 256'(0));
        tick();

        // single wb commit from source 0
        src_pl[0]      = make_req(0, 0, 1'b1);
        src_pl[0].rd   = 6'd5;
        src_pl[0].data = 128'h11;
        cv[0] = 1'b1; cwb[0] = 1'b1; bus.wb_ready = 1'b1;
        tick();
        check_val("t2_wb_valid", 256'(bus.wb_valid), 256'(1));
        check_val("t2_rd", 256'(bus.wb_rd), 256'(5));
        check_val("t2_data", 256'(bus.wb_data), 256'(128'h11));
        check_val("t2_instret", 256'(bus.instret), 256'(1));
        tick();

        // all sources writing continuously: rotation from pointer 0
        do_reset();
        bus.wb_ready = 1'b1;
        for (int i = 0; i < NUM_REQS; i++) begin
            src_pl[i] = make_req(i, seq[i]++, 1'b1);
        end
        cv = '1; cwb = '1;
        for (int k = 0; k < 6; k++) begin
            tick();
            check_val("rr_order", 256'(bus.wb_rd[5:3]), 256'(rr_order[k]));
            for (int i = 0; i < NUM_REQS; i++) begin
                if (last_acc[i]) begin
                    src_pl[i] = make_req(i, seq[i]++, 1'b1);
                    cv[i]     = 1'b1;
                end
            end
        end
        cv = '0;
        tick();
        tick();

        // output stall while a non-writing source keeps retiring
        src_pl[0] = make_req(0, seq[0]++, 1'b1);
        cv[0] = 1'b1; cwb[0] = 1'b1;
        tick();
        bus.wb_ready = 1'b0;
        src_pl[1] = make_req(1, seq[1]++, 1'b1);
        cv[1] = 1'b1; cwb[1] = 1'b1;
        base = m_instret;
        for (int k = 0; k < 3; k++) begin
            src_pl[2] = make_req(2, seq[2]++, 1'b1);
            cv[2] = 1'b1; cwb[2] = 1'b0;
            tick(1'b1, 5'b00100);
            check_val("stall_instret", 256'(bus.instret), 256'(base + 64'(k + 1)));
            check_val("stall_wb_rd", 256'(bus.wb_rd[5:3]), 256'(0));
        end
        bus.wb_ready = 1'b1;
        tick(1'b1, 5'b00010);
        tick();

        // mixed wb / non-wb acceptance in one cycle
        cv = '0;
        tick();
        src_pl[1] = make_req(1, seq[1]++, 1'b1); cv[1] = 1'b1; cwb[1] = 1'b1;
        src_pl[3] = make_req(3, seq[3]++, 1'b1); cv[3] = 1'b1; cwb[3] = 1'b0;
        src_pl[4] = make_req(4, seq[4]++, 1'b0); cv[4] = 1'b1; cwb[4] = 1'b0;
        base = m_instret;
        tick(1'b1, 5'b11010);
        check_val("mix_instret", 256'(bus.instret), 256'(base + 64'd2));
        check_val("mix_wb_rd", 256'(bus.wb_rd[5:3]), 256'(1));
        tick();

        // counter wrap
        cv = '0;
        force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFE;
        #1;
        release dut.instret_q;
        m_instret = 64'hFFFF_FFFF_FFFF_FFFE;
        src_pl[2] = make_req(2, seq[2]++, 1'b1); cv[2] = 1'b1; cwb[2] = 1'b0;
        tick();
        check_val("wrap_max", 256'(bus.instret), 256'(64'hFFFF_FFFF_FFFF_FFFF));
        src_pl[2] = make_req(2, seq[2]++, 1'b1); cv[2] = 1'b1; cwb[2] = 1'b0;
        tick();
        check_val("wrap_zero", 256'(bus.instret), 256'(0));

        // randomized traffic
        for (int c = 0; c < 300; c++) begin
            for (int i = 0; i < NUM_REQS; i++) begin
                if (!cv[i] && ($urandom_range(0, 99) < 60)) begin
                    src_pl[i] = make_req(i, seq[i]++, 1'($urandom_range(0, 1)));
                    cv[i]     = 1'b1;
                    cwb[i]    = ($urandom_range(0, 99) < 70);
                end
            end
            bus.wb_ready = ($urandom_range(0, 99) < 70);
            tick();
        end
        cv = '0;
        bus.wb_ready = 1'b1;
        tick();
        tick();
        check_val("sb_drain", 256'(sb.size()), 256'(0));

        // asynchronous reset while a writeback is held
        src_pl[0] = make_req(0, seq[0]++, 1'b1); cv[0] = 1'b1; cwb[0] = 1'b1;
        bus.wb_ready = 1'b0;
        tick();
        check_val("pre_rst_wb_valid", 256'(bus.wb_valid), 256'(1));
        #2;
        reset_n = 1'b0;
        #1;
        check_val("async_rst_wb_valid", 256'(bus.wb_valid), 256'(0));
        check_val("async_rst_instret", 256'(bus.instret), 256'(0));
        check_val("async_rst_wb_rd", 256'(bus.wb_rd), 256'(0));
        @(negedge clk);
        do_reset();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
